// File: rtl/mem_pkg.sv
// Shared memory-side definitions: address/line widths, latency default
// and responder state encoding, reused by the caches.
package mem_pkg;

    localparam int ARCH_BITS        = 32;
    localparam int LINE_BITS        = 128;
    localparam int LINE_BYTES       = LINE_BITS / 8;
    localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int DEF_NUM_LINES    = 4096;
    localparam int DEF_LATENCY      = 5;
    localparam int LAT_CNT_BITS     = 8;

    typedef logic [ARCH_BITS-1:0] mem_addr_t;
    typedef logic [LINE_BITS-1:0] mem_line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache-to-memory line request/response channel.
// master = cache side, slave = memory responder.
interface mem_line_responder_if;
    import mem_pkg::*;

    logic      req_valid;
    logic      req_ready;
    logic      req_we;
    mem_addr_t req_addr;
    mem_line_t req_wdata;
    logic      resp_valid;
    logic      resp_ready;
    mem_line_t resp_rdata;
    logic      resp_we;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_we
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_we
    );

endinterface

// File: rtl/mem_line_array.sv
// Single-port synchronous line RAM, read-first; only touched when en is
// high, so rdata holds the last read line between accesses.
module mem_line_array
    import mem_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [IDX_BITS-1:0] index,
    input  mem_line_t           wdata,
    output mem_line_t           rdata
);

    mem_line_t mem_q [NUM_LINES];
    mem_line_t rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[index];
            if (we) begin
                mem_q[index] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Main-memory line responder: one outstanding line read/write, fixed
// access latency, full-line response held until the requester takes it.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rst,
    mem_line_responder_if.slave bus
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int IDX_TOP  = LINE_OFFSET_BITS + IDX_BITS;
    localparam logic [LAT_CNT_BITS-1:0] CNT_LOAD =
        LAT_CNT_BITS'(LATENCY - 1);

    mem_state_e              state_q, state_d;
    logic [LAT_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [IDX_BITS-1:0]     idx_q, idx_d;
    mem_line_t               wdata_q, wdata_d;

    logic                    commit;
    logic                    ram_en;
    logic                    ram_we;
    logic [IDX_BITS-1:0]     ram_idx;
    mem_line_t               ram_wdata;
    mem_line_t               ram_rdata;
    logic [IDX_BITS-1:0]     req_idx;
    logic                    addr_unused;

    // Offset and upper address bits do not select a line.
    assign req_idx     = bus.req_addr[LINE_OFFSET_BITS +: IDX_BITS];
    assign addr_unused = ^{bus.req_addr[ARCH_BITS-1:IDX_TOP],
                           bus.req_addr[LINE_OFFSET_BITS-1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        commit    = 1'b0;
        ram_we    = we_q;
        ram_idx   = idx_q;
        ram_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                ram_we    = bus.req_we;
                ram_idx   = req_idx;
                ram_wdata = bus.req_wdata;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = req_idx;
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LAT_CNT_BITS'(1)) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset on the commit edge must not let the write land.
    assign ram_en = commit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    mem_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .index (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_we    = (state_q == RESP) && we_q;
    assign bus.resp_rdata = ((state_q == RESP) && !we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder (LATENCY 5 and LATENCY 1 instances)
// with a response scoreboard fed from a line-level memory model.
module tb_mem_line_responder;
    import mem_pkg::*;

    typedef struct {
        logic      we;
        mem_line_t data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_line_responder_if a5 ();
    mem_line_responder_if a1 ();

    mem_line_responder #(.NUM_LINES(4096), .LATENCY(5)) u5 (
        .clk (clk),
        .rst (rst),
        .bus (a5)
    );

    mem_line_responder #(.NUM_LINES(4096), .LATENCY(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (a1)
    );

    int n_pass = 0;
    int n_tot  = 0;

    mem_line_t model5 [int];
    mem_line_t model1 [int];
    exp_t      sb5 [$];
    exp_t      sb1 [$];

    localparam mem_line_t D_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam mem_line_t D_B = 128'h11112222_33334444_55556666_77778888;
    localparam mem_line_t D_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam mem_line_t D_P = 128'h01020304_05060708_090A0B0C_0D0E0F10;
    localparam mem_line_t D_Q = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 4) & 32'h0000_0FFF);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Entered and left at a negedge with the LATENCY-5 DUT idle.
    task automatic issue5(input logic we, input logic [31:0] addr,
                          input mem_line_t d, input int stall);
        exp_t      e;
        exp_t      got;
        int        n;
        mem_line_t held;
        chk("idle_req_ready", a5.req_ready, 1'b1);
        a5.req_valid  = 1'b1;
        a5.req_we     = we;
        a5.req_addr   = addr;
        a5.req_wdata  = d;
        a5.resp_ready = (stall == 0);
        e.we = we;
        if (we) begin
            e.data = '0;
            model5[idx_of(addr)] = d;
        end else begin
            e.data = model5[idx_of(addr)];
        end
        sb5.push_back(e);
        @(negedge clk);
        a5.req_valid = 1'b0;
        a5.req_addr  = 32'hFFFF_FFF0;
        a5.req_wdata = '1;
        n = 1;
        while (!a5.resp_valid && n < 20) begin
            chk("busy_req_ready", a5.req_ready, 1'b0);
            @(negedge clk);
            n++;
        end
        chk("latency", n, 5);
        chk("resp_req_ready", a5.req_ready, 1'b0);
        got = sb5.pop_front();
        chk("resp_rdata", a5.resp_rdata, got.data);
        chk("resp_we", a5.resp_we, got.we);
        held = a5.resp_rdata;
        if (stall > 0) begin
            a5.req_valid = 1'b1;
            a5.req_we    = 1'b1;
            a5.req_addr  = 32'h0000_5000;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_valid", a5.resp_valid, 1'b1);
                chk("stall_rdata", a5.resp_rdata, held);
                chk("stall_we", a5.resp_we, got.we);
                chk("stall_req_ready", a5.req_ready, 1'b0);
            end
            a5.req_valid  = 1'b0;
            a5.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_hs_valid", a5.resp_valid, 1'b0);
        chk("post_hs_ready", a5.req_ready, 1'b1);
    endtask

    logic [31:0] l1_addr [4] = '{32'h0000_0040, 32'h0000_0050,
                                 32'h0000_0044, 32'h0001_005C};
    logic        l1_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    mem_line_t   l1_data [4] = '{D_C, D_B, '0, '0};

    initial begin
        exp_t e;
        exp_t got;
        a5.req_valid = 1'b0; a5.req_we = 1'b0;
        a5.req_addr = '0; a5.req_wdata = '0; a5.resp_ready = 1'b0;
        a1.req_valid = 1'b0; a1.req_we = 1'b0;
        a1.req_addr = '0; a1.req_wdata = '0; a1.resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", a5.req_ready, 1'b1);
        chk("rst_resp_valid", a5.resp_valid, 1'b0);
        chk("rst_resp_rdata", a5.resp_rdata, '0);
        chk("rst_resp_we", a5.resp_we, 1'b0);
        chk("rst_l1_valid", a1.resp_valid, 1'b0);

        // preload line 0x100, then read it back
        issue5(1'b1, 32'h0000_1000, D_A, 0);
        issue5(1'b0, 32'h0000_1000, '0, 0);
        // write, then misaligned read of the same line
        issue5(1'b1, 32'h0000_2010, D_B, 0);
        issue5(1'b0, 32'h0000_201C, '0, 0);
        // response backpressure, then immediate next request
        issue5(1'b0, 32'h0000_2010, '0, 7);
        issue5(1'b0, 32'h0000_1004, '0, 0);
        // address wrap modulo NUM_LINES
        issue5(1'b1, 32'h0000_0040, D_C, 0);
        issue5(1'b0, 32'h0001_0040, '0, 0);

        // reset in the 3rd WAIT cycle drops an in-flight write
        issue5(1'b1, 32'h0000_3000, D_P, 0);
        a5.req_valid = 1'b1; a5.req_we = 1'b1;
        a5.req_addr = 32'h0000_3000; a5.req_wdata = D_Q;
        @(negedge clk);
        a5.req_valid = 1'b0;
        chk("mid_wait1_valid", a5.resp_valid, 1'b0);
        chk("mid_wait1_ready", a5.req_ready, 1'b0);
        @(negedge clk);
        chk("mid_wait2_valid", a5.resp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", a5.req_ready, 1'b1);
        chk("mid_rst_valid", a5.resp_valid, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("mid_rst_quiet", a5.resp_valid, 1'b0);
        end
        issue5(1'b0, 32'h0000_3000, '0, 0);

        // LATENCY=1: back-to-back with req_valid held high
        a1.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a1.req_valid = 1'b1;
            a1.req_we    = l1_we[k];
            a1.req_addr  = l1_addr[k];
            a1.req_wdata = l1_data[k];
            e.we = l1_we[k];
            if (l1_we[k]) begin
                e.data = '0;
                model1[idx_of(l1_addr[k])] = l1_data[k];
            end else begin
                e.data = model1[idx_of(l1_addr[k])];
            end
            sb1.push_back(e);
            @(negedge clk);
            chk("l1_resp_valid", a1.resp_valid, 1'b1);
            chk("l1_req_ready", a1.req_ready, 1'b0);
            got = sb1.pop_front();
            chk("l1_rdata", a1.resp_rdata, got.data);
            chk("l1_we", a1.resp_we, got.we);
            @(negedge clk);
            chk("l1_idle_valid", a1.resp_valid, 1'b0);
            chk("l1_idle_ready", a1.req_ready, 1'b1);
        end
        a1.req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
